// File: rtl/lamp_seq_engine.sv
`default_nettype none
// ============================================================================
//  Module   : lamp_seq_engine
//  Purpose  : Parametrised lamp-pattern sequencer. Steps through a run-time
//             writable pattern table (DEPTH entries of LAMP_N bits) with a
//             programmable per-step dwell and LOOP / ONESHOT / PINGPONG /
//             HOLD stepping modes, under start/stop control.
//  Ports    :
//    trigger  in   1        clock, rising edge
//    sysRst   in   1        asynchronous reset, active-high
//    en       in   1        sequencer clock enable (table writes ignore it)
//    start    in   1        (re)start sequence at step 0
//    stop     in   1        abort to IDLE, wins over start
//    mode     in   2        0 LOOP, 1 ONESHOT, 2 PINGPONG, 3 HOLD
//    last_idx in   AW       final step index, clamped to DEPTH-1
//    dwell    in   DWELL_W  extra enabled cycles per step
//    wr_en    in   1        pattern table write strobe
//    wr_addr  in   AW       table write address, >= DEPTH ignored
//    wr_data  in   LAMP_N   pattern to store
//    lamb     out  LAMP_N   lamp outputs (0 while IDLE)
//    counter  out  AW       current step index
//    busy     out  1        sequencer running
//    done     out  1        ONESHOT sequence completed
//  Revision : 1.0  initial release
// ============================================================================
module lamp_seq_engine #(
    parameter  int LAMP_N  = 5,
    parameter  int DEPTH   = 6,
    parameter  int DWELL_W = 4,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic               trigger,
    input  logic               sysRst,
    input  logic               en,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [AW-1:0]      last_idx,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [LAMP_N-1:0]  wr_data,
    output logic [LAMP_N-1:0]  lamb,
    output logic [AW-1:0]      counter,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    localparam logic [1:0] c_mode_loop     = 2'd0;
    localparam logic [1:0] c_mode_oneshot  = 2'd1;
    localparam logic [1:0] c_mode_pingpong = 2'd2;

    // One extra bit so DEPTH itself is representable when DEPTH is a power of 2
    localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_max_idx = AW'(DEPTH - 1);
    localparam logic [AW-1:0] c_one     = AW'(1);

    logic [1:0]         r_state;
    logic [AW-1:0]      r_index;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic               r_dir_down;
    logic [LAMP_N-1:0]  r_table [0:DEPTH-1];

    logic [1:0]         w_next_state;
    logic [AW-1:0]      w_next_index;
    logic [DWELL_W-1:0] w_next_dwell_cnt;
    logic               w_next_dir_down;
    logic [AW-1:0]      w_last;

    // Effective final index: out-of-range requests clamp to the last entry
    assign w_last = ({1'b0, last_idx} >= c_depth) ? c_max_idx : last_idx;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge trigger or posedge sysRst) begin
        if (sysRst) begin
            r_state     <= c_st_idle;
            r_index     <= '0;
            r_dwell_cnt <= '0;
            r_dir_down  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_index     <= w_next_index;
            r_dwell_cnt <= w_next_dwell_cnt;
            r_dir_down  <= w_next_dir_down;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state     = r_state;
        w_next_index     = r_index;
        w_next_dwell_cnt = r_dwell_cnt;
        w_next_dir_down  = r_dir_down;

        // stop/start bypass the enable so the sequencer can always be controlled
        if (stop) begin
            w_next_state     = c_st_idle;
            w_next_index     = '0;
            w_next_dwell_cnt = '0;
            w_next_dir_down  = 1'b0;
        end else if (start) begin
            w_next_state     = c_st_run;
            w_next_index     = '0;
            w_next_dwell_cnt = '0;
            w_next_dir_down  = 1'b0;
        end else if (en && (r_state == c_st_run)) begin
            // >= (not ==) so a lowered dwell triggers an immediate step
            if (r_dwell_cnt < dwell) begin
                w_next_dwell_cnt = r_dwell_cnt + DWELL_W'(1);
            end else begin
                w_next_dwell_cnt = '0;
                // Comparisons use >= so a shrunken last_idx is handled as "at end"
                case (mode)
                    c_mode_loop: begin
                        w_next_index = (r_index >= w_last) ? '0 : r_index + c_one;
                    end
                    c_mode_oneshot: begin
                        if (r_index >= w_last) begin
                            w_next_state = c_st_done;
                        end else begin
                            w_next_index = r_index + c_one;
                        end
                    end
                    c_mode_pingpong: begin
                        if (!r_dir_down) begin
                            if (r_index >= w_last) begin
                                w_next_dir_down = 1'b1;
                                w_next_index    = (r_index == '0) ? '0 : r_index - c_one;
                            end else begin
                                w_next_index    = r_index + c_one;
                            end
                        end else begin
                            if (r_index == '0) begin
                                w_next_dir_down = 1'b0;
                                w_next_index    = (w_last == '0) ? '0 : c_one;
                            end else begin
                                w_next_index    = r_index - c_one;
                            end
                        end
                    end
                    default: begin
                        // HOLD: index and direction frozen, dwell keeps cycling
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        lamb    = (r_state == c_st_idle) ? '0 : r_table[r_index];
        counter = r_index;
        busy    = (r_state == c_st_run);
        done    = (r_state == c_st_done);
    end

    // ------------------------------------------------------------------
    // Pattern table: independent of en, cleared by reset
    // ------------------------------------------------------------------
    always_ff @(posedge trigger or posedge sysRst) begin
        if (sysRst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= '0;
            end
        end else if (wr_en && ({1'b0, wr_addr} < c_depth)) begin
            r_table[wr_addr] <= wr_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lamp_seq_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lamp_seq_engine
//  Purpose  : Directed self-checking bench for lamp_seq_engine (default
//             parameters LAMP_N=5, DEPTH=6, DWELL_W=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_lamp_seq_engine;

    logic       trigger;
    logic       sysRst;
    logic       en;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [2:0] last_idx;
    logic [3:0] dwell;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [4:0] wr_data;
    logic [4:0] lamb;
    logic [2:0] counter;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;

    logic [4:0] pat [0:5];

    lamp_seq_engine #(
        .LAMP_N  (5),
        .DEPTH   (6),
        .DWELL_W (4)
    ) u_dut (
        .trigger  (trigger),
        .sysRst   (sysRst),
        .en       (en),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .last_idx (last_idx),
        .dwell    (dwell),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .lamb     (lamb),
        .counter  (counter),
        .busy     (busy),
        .done     (done)
    );

    initial trigger = 1'b0;
    always #5 trigger = ~trigger;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [2:0] e_cnt, input logic [4:0] e_lamb,
                           input logic e_busy, input logic e_done);
        chk({tag, ".counter"}, 32'(counter), 32'(e_cnt));
        chk({tag, ".lamb"},    32'(lamb),    32'(e_lamb));
        chk({tag, ".busy"},    32'(busy),    32'(e_busy));
        chk({tag, ".done"},    32'(done),    32'(e_done));
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge trigger);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [4:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic load_table();
        for (int i = 0; i < 6; i++) wr(3'(i), pat[i]);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        pat[0] = 5'b00000; pat[1] = 5'b11111; pat[2] = 5'b10101;
        pat[3] = 5'b10001; pat[4] = 5'b10011; pat[5] = 5'b10010;

        sysRst = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0;
        last_idx = 3'd5; dwell = 4'd0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        // Power-on reset values
        #3;
        chk_out("rst", 3'd0, 5'b0, 1'b0, 1'b0);
        #9 sysRst = 1'b0;

        load_table();
        chk_out("idle_after_load", 3'd0, 5'b0, 1'b0, 1'b0);

        // T2: LOOP, dwell 0, last 5
        en = 1'b1; mode = 2'd0; dwell = 4'd0; last_idx = 3'd5; start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("loop_s0", 3'd0, pat[0], 1'b1, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk_out($sformatf("loop_s%0d", k), 3'(k % 6), pat[k % 6], 1'b1, 1'b0);
        end

        // T1: asynchronous reset mid-run, no clock edge needed
        tick();
        chk("loop_pre_rst.counter", 32'(counter), 32'd1);
        #2 sysRst = 1'b1;
        #1 chk_out("async_rst", 3'd0, 5'b0, 1'b0, 1'b0);
        #1 sysRst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("tbl_clr_s0", 3'd0, 5'b0, 1'b1, 1'b0);
        tick();
        chk_out("tbl_clr_s1", 3'd1, 5'b0, 1'b1, 1'b0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_out("stop", 3'd0, 5'b0, 1'b0, 1'b0);
        load_table();

        // T3: ONESHOT, dwell 2, last 2
        mode = 2'd1; dwell = 4'd2; last_idx = 3'd2; start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("one_s", 3'd0, pat[0], 1'b1, 1'b0);
        for (int e = 1; e <= 9; e++) begin
            logic [2:0] ec;
            ec = (e < 3) ? 3'd0 : (e < 6) ? 3'd1 : 3'd2;
            tick();
            chk_out($sformatf("one_e%0d", e), ec, pat[ec], (e < 9), (e == 9));
        end
        tick();
        chk_out("one_hold", 3'd2, pat[2], 1'b0, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("one_restart", 3'd0, pat[0], 1'b1, 1'b0);

        // T4: PINGPONG, dwell 0, last 3
        mode = 2'd2; dwell = 4'd0; last_idx = 3'd3; start = 1'b1;
        tick();
        start = 1'b0;
        chk("pp_s0.counter", 32'(counter), 32'd0);
        begin
            logic [2:0] pp [0:6];
            pp[0] = 3'd1; pp[1] = 3'd2; pp[2] = 3'd3; pp[3] = 3'd2;
            pp[4] = 3'd1; pp[5] = 3'd0; pp[6] = 3'd1;
            for (int k = 0; k < 7; k++) begin
                tick();
                chk_out($sformatf("pp_%0d", k), pp[k], pat[pp[k]], 1'b1, 1'b0);
            end
        end
        last_idx = 3'd0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("pp_l0_%0d.counter", k), 32'(counter), 32'd0);
        end

        // T5: en toggling in LOOP
        mode = 2'd0; dwell = 4'd0; last_idx = 3'd5; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            en = (k % 2 == 0);
            tick();
            chk($sformatf("en_tog_%0d.counter", k), 32'(counter), 32'(k / 2 + 1));
        end
        en = 1'b0; stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        chk_out("stop_start", 3'd0, 5'b0, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_out("start_en0", 3'd0, pat[0], 1'b1, 1'b0);
        tick();
        chk("frozen_en0.counter", 32'(counter), 32'd0);
        en = 1'b1;

        // T6: live table write, ignored address, last_idx clamp
        mode = 2'd0; dwell = 4'd3; last_idx = 3'd5; start = 1'b1;
        tick();
        start = 1'b0;
        wr(3'd0, 5'b01110);
        chk_out("live_wr", 3'd0, 5'b01110, 1'b1, 1'b0);
        wr(3'd6, 5'b11111);
        chk_out("wr_oob", 3'd0, 5'b01110, 1'b1, 1'b0);
        dwell = 4'd0; last_idx = 3'd7;
        for (int k = 1; k <= 6; k++) begin
            logic [4:0] el;
            el = (k % 6 == 0) ? 5'b01110 : pat[k % 6];
            tick();
            chk_out($sformatf("clamp_%0d", k), 3'(k % 6), el, 1'b1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
